// File: rtl/damage_arbiter.sv
// Per-player round-robin damage arbiter with HP, cooldown and game-over tracking.
// Optional heal support is enabled with `define DAMAGE_ARBITER_HEAL_EN.
module damage_arbiter #(
    parameter int MAX_HP         = 10,
    parameter int NUM_SRC        = 4,
    parameter int COOLDOWN_TICKS = 60,
    parameter int ONE_PLAYER     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [1:0]         game_active,
    input  logic               round_start,
    input  logic [NUM_SRC-1:0] p1_dmg_req,
    input  logic [NUM_SRC-1:0] p2_dmg_req,
    input  logic               p1_heal_req,
    input  logic               p2_heal_req,
    output logic [NUM_SRC-1:0] p1_dmg_ack,
    output logic [NUM_SRC-1:0] p2_dmg_ack,
    output logic [3:0]         p1_hp,
    output logic [3:0]         p2_hp,
    output logic               p1_invuln,
    output logic               p2_invuln,
    output logic               game_over
);
    localparam int PW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t             state_q, state_d;
    logic [3:0]         hp_q [2];
    logic [3:0]         hp_d [2];
    logic [7:0]         cd_q [2];
    logic [7:0]         cd_d [2];
    logic [PW-1:0]      ptr_q [2];
    logic [PW-1:0]      ptr_d [2];
    logic [NUM_SRC-1:0] ack_q [2];
    logic [NUM_SRC-1:0] ack_d [2];
    logic               inv_q [2];
    logic               inv_d [2];
    logic               go_q, go_d;

    logic [NUM_SRC-1:0] req [2];
    logic               heal [2];
    logic               found [2];
    int                 idx [2];
    int                 j;
    logic               eval;
    logic               dead;

    assign req[0]  = p1_dmg_req;
    assign req[1]  = p2_dmg_req;
    assign heal[0] = p1_heal_req;
    assign heal[1] = p2_heal_req;

`ifndef DAMAGE_ARBITER_HEAL_EN
    logic unused_heal;
    assign unused_heal = heal[0] ^ heal[1];
`endif

    // round_start pre-empts any frame evaluation in the same cycle
    assign eval = (state_q == RUN) && frame_tick &&
                  (game_active == 2'd1) && !round_start;
    assign dead = (hp_q[0] == 4'd0) &&
                  ((ONE_PLAYER != 0) || (hp_q[1] == 4'd0));

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        j       = 0;
        for (int p = 0; p < 2; p++) begin
            hp_d[p]  = hp_q[p];
            cd_d[p]  = cd_q[p];
            ptr_d[p] = ptr_q[p];
            ack_d[p] = '0;
            found[p] = 1'b0;
            idx[p]   = 0;
        end
        if (round_start) begin
            state_d = RUN;
            go_d    = 1'b0;
            hp_d[0] = 4'(MAX_HP);
            hp_d[1] = (ONE_PLAYER != 0) ? 4'd0 : 4'(MAX_HP);
            for (int p = 0; p < 2; p++) begin
                cd_d[p]  = '0;
                ptr_d[p] = '0;
            end
        end else begin
            if (state_q == RUN && dead) begin
                state_d = OVER;
                go_d    = 1'b1;
            end
            if (eval) begin
                for (int p = 0; p < 2; p++) begin
                    if (ONE_PLAYER == 0 || p == 0) begin
                        // rotate search start at the pointer, wrap mod NUM_SRC
                        for (int i = 0; i < NUM_SRC; i++) begin
                            j = int'(ptr_q[p]) + i;
                            if (j >= NUM_SRC) j = j - NUM_SRC;
                            if (!found[p] && req[p][j]) begin
                                found[p] = 1'b1;
                                idx[p]   = j;
                            end
                        end
                        if (cd_q[p] != 8'd0) begin
                            found[p] = 1'b0;
                            cd_d[p]  = cd_q[p] - 8'd1;
                        end else if (hp_q[p] == 4'd0) begin
                            found[p] = 1'b0;
                        end
                        if (found[p]) begin
                            ack_d[p][idx[p]] = 1'b1;
                            hp_d[p]  = hp_q[p] - 4'd1;
                            cd_d[p]  = 8'(COOLDOWN_TICKS);
                            ptr_d[p] = (idx[p] == NUM_SRC - 1) ?
                                       '0 : PW'(idx[p] + 1);
                        end
`ifdef DAMAGE_ARBITER_HEAL_EN
                        if (!found[p] && heal[p] && hp_q[p] != 4'd0 &&
                            hp_q[p] < 4'(MAX_HP))
                            hp_d[p] = hp_q[p] + 4'd1;
`endif
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) inv_d[p] = (cd_d[p] != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                hp_q[p]  <= '0;
                cd_q[p]  <= '0;
                ptr_q[p] <= '0;
                ack_q[p] <= '0;
                inv_q[p] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            for (int p = 0; p < 2; p++) begin
                hp_q[p]  <= hp_d[p];
                cd_q[p]  <= cd_d[p];
                ptr_q[p] <= ptr_d[p];
                ack_q[p] <= ack_d[p];
                inv_q[p] <= inv_d[p];
            end
        end
    end

    assign p1_dmg_ack = ack_q[0];
    assign p2_dmg_ack = ack_q[1];
    assign p1_hp      = hp_q[0];
    assign p2_hp      = hp_q[1];
    assign p1_invuln  = inv_q[0];
    assign p2_invuln  = inv_q[1];
    assign game_over  = go_q;
endmodule

// File: tb/tb_damage_arbiter.sv
// Directed scoreboard bench for damage_arbiter (COOLDOWN_TICKS = 2).
// Heal steps are exercised when DAMAGE_ARBITER_HEAL_EN is defined.
module tb_damage_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] game_active = 2'd1;
    logic       round_start = 1'b0;
    logic [3:0] p1_dmg_req = '0;
    logic [3:0] p2_dmg_req = '0;
    logic       p1_heal_req = 1'b0;
    logic       p2_heal_req = 1'b0;
    logic [3:0] p1_dmg_ack, p2_dmg_ack, p1_hp, p2_hp;
    logic       p1_invuln, p2_invuln, game_over;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] a1, a2, h1, h2;
        logic       i1, i2, go;
    } exp_t;

    exp_t sb[$];

    damage_arbiter #(
        .MAX_HP(10), .NUM_SRC(4), .COOLDOWN_TICKS(2), .ONE_PLAYER(0)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .game_active(game_active), .round_start(round_start),
        .p1_dmg_req(p1_dmg_req), .p2_dmg_req(p2_dmg_req),
        .p1_heal_req(p1_heal_req), .p2_heal_req(p2_heal_req),
        .p1_dmg_ack(p1_dmg_ack), .p2_dmg_ack(p2_dmg_ack),
        .p1_hp(p1_hp), .p2_hp(p2_hp),
        .p1_invuln(p1_invuln), .p2_invuln(p2_invuln),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic tk, input logic rs,
                        input logic [1:0] ga,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic hl1,
                        input logic [3:0] ea1, input logic [3:0] ea2,
                        input logic [3:0] eh1, input logic [3:0] eh2,
                        input logic ei1, input logic ei2, input logic ego);
        exp_t e;
        frame_tick  = tk;
        round_start = rs;
        game_active = ga;
        p1_dmg_req  = r1;
        p2_dmg_req  = r2;
        p1_heal_req = hl1;
        e.tag = tag;
        e.a1 = ea1; e.a2 = ea2; e.h1 = eh1; e.h2 = eh2;
        e.i1 = ei1; e.i2 = ei2; e.go = ego;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".ack1"}, p1_dmg_ack, e.a1);
            chk({e.tag, ".ack2"}, p2_dmg_ack, e.a2);
            chk({e.tag, ".hp1"}, p1_hp, e.h1);
            chk({e.tag, ".hp2"}, p2_hp, e.h2);
            chk({e.tag, ".inv1"}, {3'b0, p1_invuln}, {3'b0, e.i1});
            chk({e.tag, ".inv2"}, {3'b0, p2_invuln}, {3'b0, e.i2});
            chk({e.tag, ".go"}, {3'b0, game_over}, {3'b0, e.go});
        end
    endtask

    initial begin
        logic [3:0] a;
        @(posedge clk);
        #1;
        step("rst", 0, 0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("idle_tick", 1, 0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        step("start", 0, 1, 1, 4'h0, 4'h0, 0, 0, 0, 10, 10, 0, 0, 0);
        step("quiet", 0, 0, 1, 4'h0, 4'h0, 0, 0, 0, 10, 10, 0, 0, 0);

        step("rr_t1", 1, 0, 1, 4'h5, 4'h0, 0, 4'h1, 0, 9, 10, 1, 0, 0);
        step("rr_t2", 1, 0, 1, 4'h5, 4'h0, 0, 0, 0, 9, 10, 1, 0, 0);
        step("rr_t3", 1, 0, 1, 4'h5, 4'h0, 0, 0, 0, 9, 10, 0, 0, 0);
        step("rr_t4", 1, 0, 1, 4'h5, 4'h0, 0, 4'h4, 0, 8, 10, 1, 0, 0);
        step("ack_drop", 0, 0, 1, 4'h5, 4'h0, 0, 0, 0, 8, 10, 1, 0, 0);
        step("cd_a", 1, 0, 1, 4'h0, 4'h0, 0, 0, 0, 8, 10, 1, 0, 0);
        step("cd_b", 1, 0, 1, 4'h0, 4'h0, 0, 0, 0, 8, 10, 0, 0, 0);

        step("both", 1, 0, 1, 4'h8, 4'h2, 0, 4'h8, 4'h2, 7, 9, 1, 1, 0);
        step("frozen", 1, 0, 0, 4'hF, 4'hF, 0, 0, 0, 7, 9, 1, 1, 0);
        step("ga2", 1, 0, 2, 4'hF, 4'hF, 0, 0, 0, 7, 9, 1, 1, 0);
        step("resume1", 1, 0, 1, 4'h0, 4'h0, 0, 0, 0, 7, 9, 1, 1, 0);
        step("resume2", 1, 0, 1, 4'h0, 4'h0, 0, 0, 0, 7, 9, 0, 0, 0);

        for (int k = 0; k < 9; k++) begin
            a = 4'h1 << ((2 + k) % 4);
            step("p2_hit", 1, 0, 1, 4'h0, 4'hF, 0, 0, a, 7,
                 4'(8 - k), 0, 1, 0);
            step("p2_cd1", 1, 0, 1, 4'h0, 4'hF, 0, 0, 0, 7,
                 4'(8 - k), 0, 1, 0);
            step("p2_cd2", 1, 0, 1, 4'h0, 4'hF, 0, 0, 0, 7,
                 4'(8 - k), 0, 0, 0);
        end
        step("p2_dead", 1, 0, 1, 4'h0, 4'hF, 0, 0, 0, 7, 0, 0, 0, 0);

        for (int k = 0; k < 7; k++) begin
            step("p1_hit", 1, 0, 1, 4'h1, 4'hF, 0, 4'h1, 0,
                 4'(6 - k), 0, 1, 0, 0);
            if (k < 6) begin
                step("p1_cd1", 1, 0, 1, 4'h1, 4'hF, 0, 0, 0,
                     4'(6 - k), 0, 1, 0, 0);
                step("p1_cd2", 1, 0, 1, 4'h1, 4'hF, 0, 0, 0,
                     4'(6 - k), 0, 0, 0, 0);
            end
        end
        step("go_set", 0, 0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("over_req", 1, 0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 1, 0, 1);
        step("over_hold", 1, 0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 1, 0, 1);
        step("restart", 0, 1, 1, 4'h0, 4'h0, 0, 0, 0, 10, 10, 0, 0, 0);

        step("rs_tick", 1, 1, 1, 4'hF, 4'hF, 0, 0, 0, 10, 10, 0, 0, 0);
        step("ptr_clr", 1, 0, 1, 4'h2, 4'h1, 0, 4'h2, 4'h1, 9, 9, 1, 1, 0);

`ifdef DAMAGE_ARBITER_HEAL_EN
        step("heal1", 1, 0, 1, 4'h0, 4'h0, 1, 0, 0, 10, 9, 1, 1, 0);
        step("heal_sat", 1, 0, 1, 4'h0, 4'h0, 1, 0, 0, 10, 9, 0, 0, 0);
        step("heal_dmg", 1, 0, 1, 4'h4, 4'h0, 1, 4'h4, 0, 9, 9, 1, 0, 0);
`else
        step("heal_off1", 1, 0, 1, 4'h0, 4'h0, 1, 0, 0, 9, 9, 1, 1, 0);
        step("heal_off2", 1, 0, 1, 4'h0, 4'h0, 1, 0, 0, 9, 9, 0, 0, 0);
        step("heal_dmg", 1, 0, 1, 4'h4, 4'h0, 1, 4'h4, 0, 8, 9, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/damage_arbiter.md
Name: damage_arbiter

Overview:
Central health controller for both players. Collects damage requests from NUM_SRC hazard sources per player (boss contact, projectiles, falling hazards) and grants at most one per player per frame_tick, using round-robin arbitration. Grants update per-player HP counters and load per-player invulnerability cooldowns. Flags player death and game over. Sits between collision detectors and the heart-rendering stage; it drives the HP values that the heart overlay displays.

Parameters:
MAX_HP, 10, starting and maximum HP per player (1..15)
NUM_SRC, 4, damage sources per player (2..8)
COOLDOWN_TICKS, 60, frame_ticks of invulnerability after a hit (1..255)
ONE_PLAYER, 0, 1 = player 2 is ignored (its HP is held at 0 and never counts for game over)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame
game_active  in  2  game mode; 1 = gameplay running
round_start  in  1  pulse: reload HP, clear cooldowns, enter RUN
p1_dmg_req  in  NUM_SRC  level damage requests for player 1, bit per source
p2_dmg_req  in  NUM_SRC  level damage requests for player 2
p1_heal_req  in  1  level heal request for player 1 (HEAL_EN only)
p2_heal_req  in  1  level heal request for player 2 (HEAL_EN only)
p1_dmg_ack  out  NUM_SRC  one-hot one-cycle grant for player 1
p2_dmg_ack  out  NUM_SRC  one-hot one-cycle grant for player 2
p1_hp  out  4  player 1 current HP
p2_hp  out  4  player 2 current HP
p1_invuln  out  1  player 1 cooldown nonzero
p2_invuln  out  1  player 2 cooldown nonzero
game_over  out  1  level: all active players at 0 HP

Behaviour:
- Reset values: p1_hp = p2_hp = 0; acks = 0; invuln = 0; game_over = 0; cooldowns = 0; round-robin pointers = 0; state IDLE.
- FSM states IDLE, RUN, OVER.
  - IDLE -> RUN on round_start.
  - RUN -> OVER when the game_over condition becomes true.
  - OVER -> RUN on round_start.
  - Any state -> IDLE on rst.
- round_start (any state) in cycle N has these effects visible at N+1:
  - p1_hp = MAX_HP.
  - p2_hp = MAX_HP, or 0 when ONE_PLAYER = 1.
  - Cooldowns cleared, pointers cleared, game_over = 0.
  - round_start has priority over a frame_tick in the same cycle; that tick is ignored.
- Evaluation: only in RUN, only in cycles where frame_tick = 1 and game_active == 1. Otherwise HP and cooldowns hold, and acks are 0.
- Per-player evaluation, each player independent:
  - Cooldown > 0: decrement cooldown. No grant. Requests are ignored, not queued.
  - Cooldown == 0, req != 0, hp > 0: grant the first set request bit at or after the pointer, wrapping modulo NUM_SRC. hp <= hp - 1; cooldown <= COOLDOWN_TICKS; pointer <= granted index + 1 (mod NUM_SRC).
  - hp == 0: no grants, no decrement, no underflow.
- Latency: ack is registered. It is asserted in cycle N+1 for a frame_tick in cycle N, in the same cycle that the new hp is visible. Ack is high for exactly one cycle.
- invuln = (cooldown != 0), registered alongside hp.
- game_over is set in the cycle after the last active player's hp becomes 0:
  - ONE_PLAYER = 0: p1_hp == 0 && p2_hp == 0.
  - ONE_PLAYER = 1: p1_hp == 0.
  - game_over stays set until round_start or rst.
- Both players hit on the same tick: both are granted independently.
- game_active leaving 1 mid-cooldown freezes the counters; they resume when it returns to 1.
- Widths: HP is 4-bit saturating. Cooldown is 8-bit. Pointer is $clog2(NUM_SRC) bits.

Optional Feature:
DAMAGE_ARBITER_HEAL_EN:
- Defined: a heal request with frame_tick in RUN and no damage grant this tick gives hp <= min(hp + 1, MAX_HP).
  - Damage wins over heal on the same tick; the heal is dropped.
  - A dead player (hp == 0) cannot be healed.
  - Cooldown is unaffected by heals.
- Undefined: heal ports are present but ignored; no heal logic is synthesized.

Test Plan:
1. rst, then round_start -> p1_hp = p2_hp = 10, game_over = 0, acks = 0, state RUN.
2. p1_dmg_req = 4'b0101 held across 3 ticks (COOLDOWN_TICKS = 2):
   - tick 1 -> p1_dmg_ack = 0001, p1_hp = 9, p1_invuln = 1.
   - ticks 2-3 -> no ack, invuln drops after tick 3.
   - tick 4 -> ack = 0100, p1_hp = 8 (round-robin rotation).
3. p1 and p2 requests on the same tick -> both acks pulse in the same cycle; both HPs decrement by 1.
4. Drive p2 to 0 HP, then p1 from 1 to 0:
   - game_over = 1 one cycle after p1_hp = 0.
   - Further requests produce no acks and HP stays 0.
   - round_start -> HP = 10, game_over = 0.
5. round_start and frame_tick in the same cycle with requests pending -> HP = MAX_HP, no ack.
6. With DAMAGE_ARBITER_HEAL_EN, p1_hp = 9:
   - heal with no damage -> 10; a second heal -> stays 10.
   - heal plus damage on the same tick -> hp 9, ack set.
